// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_type_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } lsu_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    MISALIGN = 2'b01,
    BUS      = 2'b10,
    TIMEOUT  = 2'b11
  } lsu_err_e;

  // The reserved size code 2'b11 is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] ty, input logic [1:0] lo);
    case (ty)
      BYTE:    return 1'b0;
      HALF:    return lo[0];
      WORD:    return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] ty, input logic [1:0] lo);
    case (ty)
      BYTE:    return 4'b0001 << lo;
      HALF:    return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [1:0] ty, input logic [31:0] wdata);
    case (ty)
      BYTE:    return {4{wdata[7:0]}};
      HALF:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bridge_if.sv
// Data-memory bus: req/gnt request phase followed by an rvalid response phase.
interface lsu_bridge_if;
  import lsu_pkg::*;

  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/lsu_load_align.sv
// Moves the addressed lane of the bus word to bit 0 and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] data_rdata_i,
  input  logic [1:0]  addr_lo,
  input  lsu_type_e   ty,
  input  logic        sign_ext,
  output logic [31:0] lsu_rdata_o
);
  logic [31:0] shifted;

  assign shifted = data_rdata_i >> {addr_lo, 3'b000};

  always_comb begin
    lsu_rdata_o = shifted;
    case (ty)
      BYTE:    lsu_rdata_o = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      HALF:    lsu_rdata_o = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: lsu_rdata_o = shifted;
    endcase
  end
endmodule

// File: rtl/lsu_bridge.sv
// MEM-stage load/store unit: one access becomes one req/gnt/rvalid bus transaction.
module lsu_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_busy_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rdata_valid_o,
  output logic                  lsu_err_o,
  output logic [1:0]            lsu_err_type_o,
  lsu_bridge_if.master          data_bus
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        timeout_hit, accept, complete;
  logic        err_d, err_q, rvalid_d, rvalid_q;
  lsu_err_e    err_type_d, err_type_q;
  logic [31:0] addr_q, wdata_q, rdata_q, aligned;
  logic [3:0]  be_q;
  logic [1:0]  lo_q;
  logic        we_q, sign_q;
  lsu_type_e   type_q;

  // Counter saturates so the limit compare stays valid however long we wait.
  assign cnt_inc     = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    complete   = 1'b0;
    err_d      = 1'b0;
    err_type_d = NONE;
    rvalid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (is_misaligned(lsu_type_i, lsu_addr_i[1:0])) begin
            err_d      = 1'b1;
            err_type_d = MISALIGN;
          end else begin
            accept  = 1'b1;
            state_d = WAIT_GNT;
            cnt_d   = '0;
          end
        end
      end
      WAIT_GNT: begin
        cnt_d = cnt_inc;
        if (data_bus.data_gnt_i && data_bus.data_rvalid_i) begin
          complete = 1'b1;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_type_d = TIMEOUT;
        end else if (data_bus.data_gnt_i) begin
          state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        cnt_d = cnt_inc;
        if (data_bus.data_rvalid_i) begin
          complete = 1'b1;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_type_d = TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      state_d = IDLE;
      if (data_bus.data_err_i) begin
        err_d      = 1'b1;
        err_type_d = BUS;
      end else if (!we_q) begin
        rvalid_d = 1'b1;
      end
    end
  end

  lsu_load_align u_align (
    .data_rdata_i (data_bus.data_rdata_i),
    .addr_lo      (lo_q),
    .ty           (type_q),
    .sign_ext     (sign_q),
    .lsu_rdata_o  (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_type_q <= NONE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lo_q       <= '0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      type_q     <= BYTE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_type_q <= err_type_d;
      rvalid_q   <= rvalid_d;
      if (rvalid_d) rdata_q <= aligned;
      if (accept) begin
        addr_q  <= {lsu_addr_i[31:2], 2'b00};
        wdata_q <= wdata_gen(lsu_type_i, lsu_wdata_i);
        be_q    <= be_gen(lsu_type_i, lsu_addr_i[1:0]);
        lo_q    <= lsu_addr_i[1:0];
        we_q    <= lsu_we_i;
        sign_q  <= lsu_sign_ext_i;
        type_q  <= lsu_type_e'(lsu_type_i);
      end
    end
  end

  assign lsu_busy_o        = (state_q != IDLE);
  assign lsu_rdata_o       = rdata_q;
  assign lsu_rdata_valid_o = rvalid_q;
  assign lsu_err_o         = err_q;
  assign lsu_err_type_o    = err_type_q;

  assign data_bus.data_req_o   = (state_q == WAIT_GNT);
  assign data_bus.data_addr_o  = addr_q;
  assign data_bus.data_we_o    = we_q;
  assign data_bus.data_be_o    = be_q;
  assign data_bus.data_wdata_o = wdata_q;
endmodule

// File: doc/lsu_bridge.md
Name: lsu_bridge

Overview:
- Load/store unit between the MEM stage and the data-memory bus; sits directly downstream of the pipeline's memory-access stage.
- Turns one MEM-stage access (address, size, sign, store data) into a single req/gnt/rvalid bus transaction.
- Produces lane-aligned store data with byte enables; returns sign- or zero-extended load data.
- Flags misaligned accesses, bus errors and response timeouts. Holds the pipeline through lsu_busy_o until the transaction completes.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_GNT plus WAIT_RVALID before an error is declared.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- lsu_req_i  input  1  MEM stage requests an access (level; held while lsu_busy_o=1)
- lsu_we_i  input  1  1=store, 0=load
- lsu_type_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- lsu_sign_ext_i  input  1  sign-extend load result
- lsu_addr_i  input  32  byte address
- lsu_wdata_i  input  32  store data, LSB-justified
- lsu_busy_o  output  1  stall request to the pipeline
- lsu_rdata_o  output  32  extended load data
- lsu_rdata_valid_o  output  1  one-cycle pulse when lsu_rdata_o is valid
- lsu_err_o  output  1  one-cycle pulse on misaligned access, bus error or timeout
- lsu_err_type_o  output  2  01 misaligned, 10 bus error, 11 timeout
- data_req_o  output  1  bus request
- data_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- data_we_o  output  1  bus write enable
- data_be_o  output  4  byte enables
- data_wdata_o  output  32  lane-replicated store data
- data_gnt_i  input  1  bus grant
- data_rvalid_i  input  1  bus response valid (loads and stores)
- data_rdata_i  input  32  bus read data
- data_err_i  input  1  bus error, qualified by data_rvalid_i

Behaviour:
- Reset: state=IDLE, timeout counter=0. All outputs 0, including lsu_rdata_o, data_addr_o, data_be_o and data_wdata_o.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, lsu_req_i=1:
  - Misaligned when: half with addr[0]=1, word with addr[1:0]!=0, or type=11.
  - Misaligned: no bus request; lsu_err_o=1 with type 01 on the next cycle; stay in IDLE.
  - Aligned: register addr/we/be/wdata/type/sign/addr[1:0]; go to WAIT_GNT; lsu_busy_o=1 from that cycle.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- WAIT_GNT:
  - data_req_o=1; address, we, be and wdata held stable until the grant.
  - On data_gnt_i: drop data_req_o next cycle, go to WAIT_RVALID.
  - If data_gnt_i and data_rvalid_i arrive in the same cycle: complete directly and return to IDLE.
- WAIT_RVALID, on data_rvalid_i:
  - If data_err_i: lsu_err_o pulse with type 10; lsu_rdata_valid_o stays 0.
  - Else, load: lsu_rdata_o = (data_rdata_i >> 8*addr[1:0]) truncated to size, extended per sign bit; lsu_rdata_valid_o pulses.
  - Else, store: no valid pulse.
  - Return to IDLE.
- Completion latency: the valid/err pulse and lsu_busy_o=0 appear in the cycle after the rvalid. Minimum load latency is 2 cycles from acceptance (grant and rvalid in the same cycle).
- Timeout:
  - Counter increments every cycle in WAIT_GNT and WAIT_RVALID; it saturates, never wraps.
  - Counter reaching TIMEOUT_CYCLES gives lsu_err_o with type 11, data_req_o deasserted, return to IDLE.
  - A late rvalid received in IDLE is ignored.
- Back-to-back: a new request is accepted in the same cycle the FSM returns to IDLE. There is no dead cycle beyond the one-cycle completion.
- lsu_rdata_o holds its last value between valid pulses.
- Asynchronous reset mid-transaction: immediate return to IDLE; data_req_o drops without waiting for the grant.

Decomposition:
- Shared package lsu_pkg:
  - typedef lsu_type_e (BYTE, HALF, WORD).
  - typedef lsu_state_e.
  - typedef lsu_err_e (NONE, MISALIGN, BUS, TIMEOUT).
  - Function be_gen(type, addr_lo).
- Sub-module lsu_load_align: combinational shift and extend from data_rdata_i/addr_lo/type/sign to lsu_rdata_o.

Test Plan:
- Word store, addr 0x88, wdata 0xDEADBEEF, gnt after 2 cycles, rvalid 1 cycle later:
  - data_addr_o=0x88, data_be_o=1111 held stable through the wait.
  - mem[34]=0xDEADBEEF; busy for 4 cycles; no valid pulse.
- Byte load, addr 0x8E, signed, bus data 0x80FF1234, gnt and rvalid in the same cycle:
  - data_be_o=0100; lsu_rdata_o=0xFFFFFFFF.
  - Same access unsigned: lsu_rdata_o=0x000000FF.
- Half store, addr 0x8A, wdata 0x0000ABCD:
  - data_be_o=1100, data_wdata_o=0xABCDABCD.
  - Following signed half load returns 0xFFFFABCD.
- Misaligned word load at addr 0x8D:
  - No data_req_o; lsu_err_o pulse with type 01 one cycle later.
  - A load at 0x8C on the following cycle is accepted normally.
- data_gnt_i held low 16 cycles:
  - lsu_err_o with type 11 at cycle 16; data_req_o drops; FSM back in IDLE.
- rvalid with data_err_i=1 on a load: lsu_err_o with type 10, lsu_rdata_valid_o=0.
- rst_n pulled low while in WAIT_GNT: data_req_o=0 immediately; after release, all outputs are 0.
